// File: rtl/ff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ff_write_arbiter
// Brief    : Round-robin write arbiter/sequencer for a shared ff register,
//            with readback verify, bounded retry and per-requester ack/err.
// Revision : 1.0 - initial release
// ============================================================================
module ff_write_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       err,
   output logic                  ff_clk_en,
   output logic [WIDTH-1:0]      ff_d,
   input  logic [WIDTH-1:0]      ff_q,
   output logic                  busy
);

   localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_PW-1:0]   r_ptr;
   logic [c_PW-1:0]   w_ptr_nxt;
   logic [c_PW-1:0]   r_sel;
   logic [c_PW-1:0]   w_sel_nxt;
   logic [c_PW-1:0]   w_pick;
   logic [c_PW-1:0]   w_idx;
   logic              w_found;
   logic [c_RW-1:0]   r_retry;
   logic [c_RW-1:0]   w_retry_nxt;
   logic [NREQ-1:0]   w_gnt_nxt;
   logic [NREQ-1:0]   w_ack_nxt;
   logic [NREQ-1:0]   w_err_nxt;
   logic [NREQ-1:0]   w_sel_oh;
   logic              w_clk_en_nxt;
   logic [WIDTH-1:0]  w_d_nxt;
   logic [WIDTH-1:0]  w_pick_data;

   // First requester at or after r_ptr, wrapping past NREQ-1.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = r_ptr;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = c_PW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_pick_data = wdata[int'(w_pick)*WIDTH +: WIDTH];
   assign w_sel_oh    = NREQ'(1) << r_sel;

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_sel_nxt    = r_sel;
      w_retry_nxt  = r_retry;
      w_gnt_nxt    = gnt;
      w_ack_nxt    = '0;
      w_err_nxt    = '0;
      w_clk_en_nxt = 1'b0;
      w_d_nxt      = ff_d;
      case (r_state)
         IDLE: begin
            w_gnt_nxt = '0;
            w_d_nxt   = '0;
            if (w_found) begin
               w_sel_nxt    = w_pick;
               w_gnt_nxt    = NREQ'(1) << w_pick;
               w_d_nxt      = w_pick_data;
               w_clk_en_nxt = 1'b1;
               w_state_nxt  = WRITE;
            end
         end
         WRITE: begin
            w_state_nxt = VERIFY;
         end
         VERIFY: begin
            // ff_d still holds the data latched at grant time.
            if (ff_q == ff_d) begin
               w_ack_nxt   = w_sel_oh;
               w_state_nxt = DONE;
            end else if (r_retry < c_RW'(MAX_RETRY)) begin
               w_retry_nxt  = r_retry + c_RW'(1);
               w_clk_en_nxt = 1'b1;
               w_state_nxt  = WRITE;
            end else begin
               w_err_nxt   = w_sel_oh;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_gnt_nxt   = '0;
            w_d_nxt     = '0;
            w_retry_nxt = '0;
            w_ptr_nxt   = (r_sel == c_PW'(NREQ - 1)) ? '0 : r_sel + c_PW'(1);
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_sel     <= '0;
         r_retry   <= '0;
         gnt       <= '0;
         ack       <= '0;
         err       <= '0;
         ff_clk_en <= 1'b0;
         ff_d      <= '0;
         busy      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_sel     <= w_sel_nxt;
         r_retry   <= w_retry_nxt;
         gnt       <= w_gnt_nxt;
         ack       <= w_ack_nxt;
         err       <= w_err_nxt;
         ff_clk_en <= w_clk_en_nxt;
         ff_d      <= w_d_nxt;
         busy      <= (w_state_nxt != IDLE);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_write_arbiter
// Brief    : Scoreboard bench for ff_write_arbiter with a faulty-bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_write_arbiter;

   localparam int NREQ      = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_RETRY = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       err;
   logic                  ff_clk_en;
   logic [WIDTH-1:0]      ff_d;
   logic [WIDTH-1:0]      ff_q;
   logic                  busy;

   ff_write_arbiter #(
      .NREQ      (NREQ),
      .WIDTH     (WIDTH),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .wdata     (wdata),
      .gnt       (gnt),
      .ack       (ack),
      .err       (err),
      .ff_clk_en (ff_clk_en),
      .ff_d      (ff_d),
      .ff_q      (ff_q),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         w;
      logic [7:0] data;
      bit         is_err;
      int         nwr;
      int         base;
      int         done_cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         nchecks = 0;
   int         nerr = 0;
   int         cyc = 0;
   int         wr_cnt = 0;
   int         fail_until = 0;
   int         m_ptr = 0;
   logic [7:0] bank_q = 8'h00;
   logic [7:0] last_wd = 8'h00;
   logic [7:0] mask = 8'h01;

   assign ff_q = bank_q;

   // Register bank: first (fail_until - base) writes of an operation land corrupted.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ff_clk_en) begin
         bank_q  <= (wr_cnt < fail_until) ? (ff_d ^ mask) : ff_d;
         last_wd <= ff_d;
         wr_cnt  <= wr_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (((v >> ((p + k) % NREQ)) & 4'd1) != 4'd0) return (p + k) % NREQ;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
         chk("ack_err_excl", 32'(ack & err), 32'd0);
         if ((ack | err) != '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", {24'd0, ack, err}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("ack", 32'(ack), mon_e.is_err ? 32'd0 : (32'd1 << mon_e.w));
               chk("err", 32'(err), mon_e.is_err ? (32'd1 << mon_e.w) : 32'd0);
               chk("gnt_at_resp", 32'(gnt), 32'd1 << mon_e.w);
               chk("busy_at_resp", 32'(busy), 32'd1);
               chk("written_data", 32'(last_wd), 32'(mon_e.data));
               chk("write_count", 32'(wr_cnt - mon_e.base), 32'(mon_e.nwr));
               chk("resp_cycle", 32'(cyc), 32'(mon_e.done_cyc));
            end
         end
      end
   end

   // Called at a negedge with the arbiter idle; returns at the negedge before
   // the next sampling edge.
   task automatic do_op(input logic [3:0] vec, input logic [31:0] wd, input int f,
                        input bit hold, input bit mutate);
      exp_t e;
      int   w;
      w          = rr_pick(vec, m_ptr);
      e.w        = w;
      e.data     = wd[w*8 +: 8];
      e.is_err   = (f > MAX_RETRY);
      e.nwr      = e.is_err ? MAX_RETRY + 1 : f + 1;
      e.base     = wr_cnt;
      e.done_cyc = cyc + 1 + 2 * e.nwr;
      fail_until = wr_cnt + f;
      mask       = 8'($urandom_range(1, 255));
      sb.push_back(e);
      m_ptr      = (w + 1) % NREQ;
      req        = vec;
      wdata      = wd;
      @(negedge clk);
      chk("grant", 32'(gnt), 32'd1 << w);
      chk("write_en", 32'(ff_clk_en), 32'd1);
      chk("write_data", 32'(ff_d), 32'(e.data));
      chk("busy", 32'(busy), 32'd1);
      if (!hold) req = '0;
      if (mutate) wdata = $urandom;
      @(negedge clk);
      chk("write_en_off", 32'(ff_clk_en), 32'd0);
      repeat (2 * e.nwr) @(negedge clk);
   endtask

   task automatic reset_in_verify(input logic [3:0] vec, input logic [31:0] wd);
      fail_until = wr_cnt;
      req        = vec;
      wdata      = wd;
      @(negedge clk);
      req = '0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_clk_en", 32'(ff_clk_en), 32'd0);
      chk("rst_d", 32'(ff_d), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
   endtask

   initial begin
      req   = '0;
      wdata = '0;
      repeat (2) @(negedge clk);
      chk("init_gnt", 32'(gnt), 32'd0);
      chk("init_ack", 32'(ack | err), 32'd0);
      chk("init_clk_en", 32'(ff_clk_en), 32'd0);
      chk("init_d", 32'(ff_d), 32'd0);
      chk("init_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(4'b0001, 32'h000000A5, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) do_op(4'b1111, 32'h44332211, 0, 1'b1, 1'b0);
      do_op(4'b0100, 32'h005A0000, 3, 1'b0, 1'b0);
      do_op(4'b1111, 32'h44332211, 0, 1'b0, 1'b0);
      do_op(4'b1001, 32'h000000C3, 1, 1'b0, 1'b0);
      do_op(4'b0010, 32'h00007E00, 0, 1'b0, 1'b1);
      reset_in_verify(4'b0100, 32'h00BB0000);
      do_op(4'b1000, 32'hD2000000, 0, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req = '0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         do_op(4'($urandom_range(1, 15)), $urandom,
               ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      req = '0;
      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ff_write_arbiter.md
Name: ff_write_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared WIDTH-bit register built from ff cells (clk_en/d/q interface).
- Up to NREQ requesters compete to write the register. The block grants one requester, drives the register's clock enable and data, reads q back to verify the write, retries on mismatch, and signals completion per requester.
- Sits between requesting blocks and the register bank, in the register's clock domain.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, register width in bits
MAX_RETRY, 2, extra write attempts after a failed verify before reporting error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester write request, level, held until ack or err
wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, high for the whole operation
ack  output  NREQ  one-cycle pulse to granted requester on verified write
err  output  NREQ  one-cycle pulse to granted requester when retries are exhausted
ff_clk_en  output  1  clock enable to register bank
ff_d  output  WIDTH  data to register bank
ff_q  input  WIDTH  register bank output, readback
busy  output  1  high when state != IDLE

Behaviour:
- All outputs are registered. On rst_n low, immediately: gnt=0, ack=0, err=0, ff_clk_en=0, ff_d=0, busy=0, state=IDLE, rr pointer=0, retry count=0.
- The register bank updates q on the rising edge where ff_clk_en=1; q is visible the following cycle.
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE:
  - If any req is set, select the first set bit searching from index ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - Latch the selected wdata into an internal data register.
  - Next cycle: gnt[sel]=1, ff_d=latched data, ff_clk_en=1, state=WRITE.
  - If no req is set, stay in IDLE with all outputs 0.
- WRITE: lasts exactly one cycle with ff_clk_en=1. Then ff_clk_en=0 and state=VERIFY.
- VERIFY: lasts one cycle; compare ff_q with the latched data.
  - Match: ack[sel] pulses 1 in the next cycle, state=DONE.
  - Mismatch and retry count < MAX_RETRY: increment retry count, state=WRITE (ff_clk_en=1 again, same data).
  - Mismatch and retry count == MAX_RETRY: err[sel] pulses 1 in the next cycle, state=DONE.
- DONE: lasts one cycle.
  - gnt cleared, retry count cleared, ptr = sel+1 modulo NREQ, state=IDLE.
  - ack/err deassert in the cycle after their pulse.
- Latency on a clean write: req seen at edge N; gnt and ff_clk_en high after edge N+1; register written at edge N+2; ack high after edge N+3; IDLE after edge N+4. A new grant is possible after edge N+5.
- The requester may drop req during an operation; the operation still completes with the latched data and the ack/err pulse is still issued.
- wdata changes after the grant edge are ignored.
- Multiple simultaneous reqs: exactly one grant. A requester that is continuously requesting waits at most NREQ-1 operations.
- ptr wraps from NREQ-1 to 0.
- gnt is always one-hot or zero. ack and err are never both set. ack|err pulses exactly once per grant.
- Reset mid-operation: everything returns to reset values at once; the in-flight requester receives no ack/err. The register bank may or may not have been written.
- busy=1 from the cycle gnt rises through the DONE cycle.

Test Plan:
- Single write: reset, then req=4'b0001 with wdata[7:0]=8'hA5 and ff_q tracking a model ff -> gnt[0] is high 1 cycle after the req edge, ff_clk_en pulses for 1 cycle with ff_d=A5, ack[0] pulses 3 cycles after the req edge, err=0.
- Round-robin: req=4'b1111 held, distinct data 11/22/33/44 -> grants in order 0,1,2,3,0. Each ack lands after the matching write. Never more than one gnt bit high.
- Verify failure: bank model forces ff_q=00 and req[2] writes 8'h5A -> ff_clk_en pulses 3 times (1+MAX_RETRY), then a single err[2] pulse, no ack. ptr advances to 3.
- Transient failure: ff_q mismatches on the first write only, data 8'hC3 -> 2 write pulses, then ack, no err.
- Req dropped and data changed: req[1] drops and wdata[1] changes the cycle after the grant -> the originally latched value is written and ack[1] still pulses.
- Async reset in VERIFY: assert rst_n=0 mid-cycle -> all outputs are 0 with no clock edge. After release, req[3] alone is granted on the next opportunity (ptr=0 search wraps to 3).
